// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD framebuffer scan-out engine.
// Holds the FSM state type, default command byte and DC levels.
package lcd_pkg;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      FETCH,
      SHIFT,
      DONE
   } lcd_state_e;

   localparam logic [7:0] CMD_WRITE_DEF = 8'h2C;

   localparam logic DC_CMD  = 1'b0;
   localparam logic DC_DATA = 1'b1;

endpackage

// File: rtl/lcd_spi_byte_tx.sv
// Mode-0 serial byte transmitter, MSB first, sclk idle low.
// Ports: clk, rst_n, load_i/data_i (start a byte), sclk_o, mosi_o,
// done_o (high in the last clk cycle of the byte's final sclk-high phase).
module lcd_spi_byte_tx
   import lcd_pkg::*;
#(
   parameter int CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load_i,
   input  logic [7:0] data_i,
   output logic       sclk_o,
   output logic       mosi_o,
   output logic       done_o
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);

   logic          act_q, act_d;
   logic [7:0]    sr_q, sr_d;
   logic [2:0]    bit_q, bit_d;
   logic [DW-1:0] div_q, div_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic          half_end;

   assign half_end = act_q && (div_q == DIV_MAX);

   always_comb begin
      act_d  = act_q;
      sr_d   = sr_q;
      bit_d  = bit_q;
      div_d  = div_q;
      sclk_d = sclk_q;
      mosi_d = mosi_q;
      if (load_i) begin
         act_d  = 1'b1;
         sr_d   = data_i;
         bit_d  = 3'd0;
         div_d  = '0;
         sclk_d = 1'b0;
         mosi_d = data_i[7];
      end else if (act_q) begin
         if (half_end) begin
            div_d = '0;
            if (!sclk_q) begin
               sclk_d = 1'b1;
            end else begin
               // Falling edge: the only point where mosi may move.
               sclk_d = 1'b0;
               if (bit_q == 3'd7) begin
                  act_d = 1'b0;
               end else begin
                  bit_d  = bit_q + 3'd1;
                  sr_d   = {sr_q[6:0], 1'b0};
                  mosi_d = sr_q[6];
               end
            end
         end else begin
            div_d = div_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_q  <= 1'b0;
         sr_q   <= 8'h00;
         bit_q  <= 3'd0;
         div_q  <= '0;
         sclk_q <= 1'b0;
         mosi_q <= 1'b0;
      end else begin
         act_q  <= act_d;
         sr_q   <= sr_d;
         bit_q  <= bit_d;
         div_q  <= div_d;
         sclk_q <= sclk_d;
         mosi_q <= mosi_d;
      end
   end

   assign sclk_o = sclk_q;
   assign mosi_o = mosi_q;
   assign done_o = half_end && sclk_q && (bit_q == 3'd7);

endmodule

// File: rtl/lcd_fb_scanout.sv
// Walks the 1-bpp framebuffer, packs 8 pixels/byte MSB first and streams
// a command byte plus all pixel bytes to the panel over cs_n/sclk/mosi/dc.
// Ports: clk, rst_n, start, busy, frame_done, fb_en/fb_addr/fb_dout (RAM
// read port, 1-cycle latency), lcd_cs_n, lcd_sclk, lcd_mosi, lcd_dc.
// Macro LCD_CONT_REFRESH_EN: frames repeat back to back after one start.
module lcd_fb_scanout
   import lcd_pkg::*;
#(
   parameter int         H_PIXELS  = 128,
   parameter int         V_LINES   = 128,
   parameter int         ADDR_W    = 14,
   parameter int         CLK_DIV   = 4,
   parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              frame_done,
   output logic              fb_en,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic              fb_dout,
   output logic              lcd_cs_n,
   output logic              lcd_sclk,
   output logic              lcd_mosi,
   output logic              lcd_dc
);

   localparam int TOTAL_I = H_PIXELS * V_LINES;
   localparam logic [ADDR_W:0] TOTAL = TOTAL_I[ADDR_W:0];

`ifdef LCD_CONT_REFRESH_EN
   localparam logic BUSY_IN_DONE = 1'b1;
`else
   localparam logic BUSY_IN_DONE = 1'b0;
`endif

   lcd_state_e        state_q, state_d;
   logic [ADDR_W:0]   base_q, base_d;
   logic [ADDR_W:0]   base_inc;
   logic [3:0]        k_q, k_d;
   logic [7:0]        pix_q, pix_d;
   logic              fb_en_q, fb_en_d;
   logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
   logic              cs_n_q, cs_n_d;
   logic              dc_q, dc_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              tx_load;
   logic [7:0]        tx_data;
   logic              tx_done;

   lcd_spi_byte_tx #(
      .CLK_DIV (CLK_DIV)
   ) u_tx (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (tx_load),
      .data_i (tx_data),
      .sclk_o (lcd_sclk),
      .mosi_o (lcd_mosi),
      .done_o (tx_done)
   );

   assign base_inc = base_q + (ADDR_W+1)'(8);

   always_comb begin
      state_d   = state_q;
      base_d    = base_q;
      k_d       = k_q;
      pix_d     = pix_q;
      fb_en_d   = fb_en_q;
      fb_addr_d = fb_addr_q;
      cs_n_d    = cs_n_q;
      dc_d      = dc_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      tx_load   = 1'b0;
      tx_data   = pix_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = CMD;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
            end
         end
         CMD: begin
            tx_load = 1'b1;
            tx_data = CMD_WRITE;
            dc_d    = DC_CMD;
            state_d = SHIFT;
         end
         FETCH: begin
            // k 0..7 issue reads; RAM data lags by one, so k 1..8 capture.
            k_d = k_q + 4'd1;
            if (k_q != 4'd0 && k_q <= 4'd8) begin
               pix_d = {pix_q[6:0], fb_dout};
            end
            if (k_q == 4'd7) begin
               fb_en_d = 1'b0;
            end else if (fb_en_q) begin
               fb_addr_d = fb_addr_q + ADDR_W'(1);
            end
            if (k_q == 4'd9) begin
               tx_load = 1'b1;
               tx_data = pix_q;
               dc_d    = DC_DATA;
               k_d     = 4'd0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (tx_done) begin
               if (dc_q == DC_CMD) begin
                  state_d   = FETCH;
                  k_d       = 4'd0;
                  fb_en_d   = 1'b1;
                  fb_addr_d = base_q[ADDR_W-1:0];
               end else if (base_inc == TOTAL) begin
                  state_d   = DONE;
                  base_d    = '0;
                  fb_addr_d = '0;
                  cs_n_d    = 1'b1;
                  busy_d    = BUSY_IN_DONE;
                  done_d    = 1'b1;
               end else begin
                  state_d   = FETCH;
                  k_d       = 4'd0;
                  base_d    = base_inc;
                  fb_en_d   = 1'b1;
                  fb_addr_d = base_inc[ADDR_W-1:0];
               end
            end
         end
         DONE: begin
`ifdef LCD_CONT_REFRESH_EN
            state_d = CMD;
            cs_n_d  = 1'b0;
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         base_q    <= '0;
         k_q       <= 4'd0;
         pix_q     <= 8'h00;
         fb_en_q   <= 1'b0;
         fb_addr_q <= '0;
         cs_n_q    <= 1'b1;
         dc_q      <= DC_CMD;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         base_q    <= base_d;
         k_q       <= k_d;
         pix_q     <= pix_d;
         fb_en_q   <= fb_en_d;
         fb_addr_q <= fb_addr_d;
         cs_n_q    <= cs_n_d;
         dc_q      <= dc_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   assign busy       = busy_q;
   assign frame_done = done_q;
   assign fb_en      = fb_en_q;
   assign fb_addr    = fb_addr_q;
   assign lcd_cs_n   = cs_n_q;
   assign lcd_dc     = dc_q;

endmodule

// File: tb/tb_lcd_fb_scanout.sv
// Self-checking bench for lcd_fb_scanout, small 8x2 frame (3 bytes).
// Serial monitor decodes bytes on sclk rising edges; RAM has 1-cycle latency.
module tb_lcd_fb_scanout;

   localparam int CD = 4;

`ifdef LCD_CONT_REFRESH_EN
   localparam bit CONT = 1'b1;
`else
   localparam bit CONT = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       fb_dout = 1'b0;
   logic       busy, frame_done, fb_en;
   logic [3:0] fb_addr;
   logic       cs_n, sclk, mosi, dc;

   always #5 clk = ~clk;

   lcd_fb_scanout #(
      .H_PIXELS  (8),
      .V_LINES   (2),
      .ADDR_W    (4),
      .CLK_DIV   (CD),
      .CMD_WRITE (8'h2C)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .busy       (busy),
      .frame_done (frame_done),
      .fb_en      (fb_en),
      .fb_addr    (fb_addr),
      .fb_dout    (fb_dout),
      .lcd_cs_n   (cs_n),
      .lcd_sclk   (sclk),
      .lcd_mosi   (mosi),
      .lcd_dc     (dc)
   );

   logic [15:0] mem = 16'h0;
   always @(posedge clk) if (fb_en) fb_dout <= mem[fb_addr];

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [7:0] rx_q[$];
   bit         dcs[$];
   int         lens[$];
   int         runs[$];
   int         addrs[$];
   int         fd_cnt = 0;
   int         glitch = 0;
   int         bitn = 0, t0 = 0, run = 0;
   logic [7:0] sh = 8'h0;
   logic       sclk_p = 1'b0, mosi_p = 1'b0;

   always @(negedge clk) begin
      if (!rst_n) begin
         bitn = 0; run = 0; sclk_p = 1'b0; mosi_p = 1'b0;
      end else begin
         if (!cs_n && sclk && !sclk_p) begin
            if (bitn == 0) t0 = cyc;
            sh = {sh[6:0], mosi};
            bitn++;
            if (bitn == 8) begin
               rx_q.push_back(sh);
               dcs.push_back(dc);
               lens.push_back(cyc - t0);
               bitn = 0;
            end
         end
         if (sclk && sclk_p && mosi !== mosi_p) glitch++;
         if (frame_done) fd_cnt++;
         if (fb_en) begin
            addrs.push_back(int'(fb_addr));
            run++;
         end else if (run > 0) begin
            runs.push_back(run);
            run = 0;
         end
         sclk_p = sclk;
         mosi_p = mosi;
      end
   end

   int total = 0, bad = 0;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model_byte(input logic [15:0] p,
                                             input int b);
      logic [7:0] r;
      for (int i = 0; i < 8; i++) r[7-i] = p[8*b+i];
      return r;
   endfunction

   task automatic clear_mon();
      rx_q.delete(); dcs.delete(); lens.delete();
      runs.delete(); addrs.delete(); fd_cnt = 0;
   endtask

   task automatic run_frame(input logic [15:0] pat, input logic [7:0] e1,
                            input logic [7:0] e2, input bit mid_start);
      bit seen;
      rst_n = 1'b0; start = 1'b0;
      @(negedge clk); @(negedge clk);
      mem = pat;
      clear_mon();
      rst_n = 1'b1;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("start_busy", busy, 1);
      check("start_csn", cs_n, 0);
      seen = 1'b0;
      for (int n = 0; n < 3000 && !seen; n++) begin
         start = (mid_start && n == 150);
         @(negedge clk);
         if (frame_done) seen = 1'b1;
      end
      start = 1'b0;
      check("frame_done_seen", seen, 1);
      check("done_csn", cs_n, 1);
      check("done_addr", fb_addr, 0);
      check("done_busy", busy, CONT);
      @(negedge clk);
      check("fd_count", fd_cnt, 1);
      check("byte_count", rx_q.size(), 3);
      if (rx_q.size() >= 3) begin
         check("cmd_byte", rx_q[0], 8'h2C);
         check("cmd_dc", dcs[0], 0);
         check("cmd_len", lens[0], 14 * CD);
         check("data1", rx_q[1], e1);
         check("data1_dc", dcs[1], 1);
         check("data2", rx_q[2], e2);
         check("data2_dc", dcs[2], 1);
      end
      check("fetch_runs", runs.size(), 2);
      if (runs.size() >= 2) check("fetch2_len", runs[1], 8);
      check("fetch_addr_cnt", addrs.size(), 16);
      if (addrs.size() >= 16) begin
         for (int i = 8; i < 16; i++) check("fetch2_addr", addrs[i], i);
      end
      if (!CONT) begin
         repeat (200) @(negedge clk);
         check("idle_fd", fd_cnt, 1);
         check("idle_bytes", rx_q.size(), 3);
         check("idle_busy", busy, 0);
         check("idle_csn", cs_n, 1);
      end
   endtask

   typedef struct {
      logic [15:0] pat;
      logic [7:0]  b1;
      logic [7:0]  b2;
   } vec_t;

   vec_t vecs[6];

   initial begin
      bit ok;
      logic [15:0] rp;

      vecs[0] = '{16'h0F81, 8'h81, 8'hF0};
      vecs[1] = '{16'h0001, 8'h80, 8'h00};
      vecs[2] = '{16'h8000, 8'h00, 8'h01};
      vecs[3] = '{16'hFFFF, 8'hFF, 8'hFF};
      vecs[4] = '{16'hAAAA, 8'h55, 8'h55};
      vecs[5] = '{16'h0000, 8'h00, 8'h00};

      // Held reset.
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_csn", cs_n, 1);
      check("rst_sclk", sclk, 0);
      check("rst_busy", busy, 0);
      check("rst_fben", fb_en, 0);
      check("rst_addr", fb_addr, 0);

      foreach (vecs[i]) run_frame(vecs[i].pat, vecs[i].b1, vecs[i].b2, 1'b0);

      // Start pulse mid-frame must be ignored.
      run_frame(16'h3C5A, model_byte(16'h3C5A, 0), model_byte(16'h3C5A, 1), 1'b1);

      for (int it = 0; it < 6; it++) begin
         rp = 16'($urandom);
         run_frame(rp, model_byte(rp, 0), model_byte(rp, 1), it == 2);
      end

      // Asynchronous reset in the middle of a data byte, between edges.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      mem = 16'hFFFF;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 1'b0;
      for (int n = 0; n < 500 && !ok; n++) begin
         @(negedge clk);
         if (sclk && dc) ok = 1'b1;
      end
      check("reach_data_shift", ok, 1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_csn", cs_n, 1);
      check("arst_sclk", sclk, 0);
      check("arst_mosi", mosi, 0);
      check("arst_dc", dc, 0);
      check("arst_busy", busy, 0);
      check("arst_fben", fb_en, 0);
      check("arst_addr", fb_addr, 0);
      check("arst_done", frame_done, 0);
      @(negedge clk);

      if (CONT) begin
         int nd, cs_hi, busy_lo;
         rst_n = 1'b0;
         @(negedge clk);
         mem = 16'h1234;
         clear_mon();
         rst_n = 1'b1;
         @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         nd = 0; cs_hi = 0; busy_lo = 0;
         for (int n = 0; n < 1500 && nd < 3; n++) begin
            start = (n == 300);
            @(negedge clk);
            if (cs_n) cs_hi++;
            if (!busy) busy_lo++;
            if (frame_done) nd++;
         end
         start = 1'b0;
         check("cont_frames", nd, 3);
         check("cont_cs_hi", cs_hi, 3);
         check("cont_busy_lo", busy_lo, 0);
         check("cont_bytes", rx_q.size(), 9);
         if (rx_q.size() >= 9) begin
            check("cont_cmd2", rx_q[3], 8'h2C);
            check("cont_d2", rx_q[7], model_byte(16'h1234, 0));
         end
         rst_n = 1'b0;
         @(negedge clk);
      end

      check("mosi_stable_high", glitch, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
